// File: rtl/countdown_pkg.sv
// Shared types and constants for the four-digit BCD countdown timer.
// Digit order in digits_t is [0]=hundredths .. [3]=tens of seconds.
package countdown_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SET0  = 3'd1;
  localparam logic [2:0] ST_SET1  = 3'd2;
  localparam logic [2:0] ST_SET2  = 3'd3;
  localparam logic [2:0] ST_SET3  = 3'd4;
  localparam logic [2:0] ST_RUN   = 3'd5;
  localparam logic [2:0] ST_ALARM = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SET0  = ST_SET0,
    SET1  = ST_SET1,
    SET2  = ST_SET2,
    SET3  = ST_SET3,
    RUN   = ST_RUN,
    ALARM = ST_ALARM
  } state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [3:0][3:0] digits_t;

  // Ripple borrow from the hundredths upwards; digits at 0 wrap to 9.
  function automatic digits_t bcd_dec(input digits_t v);
    digits_t r;
    logic    borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[i] == 4'd0) begin
          r[i] = BCD_MAX;
        end else begin
          r[i]   = v[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button synchronizer and falling-edge detector (raw button is active-low).
// Gives exactly one press_o cycle per press; there is no debounce.
module btn_edge (
  input  logic clk100_i,
  input  logic rstn_i,
  input  logic btn_i,
  output logic press_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], ~btn_i};
  end

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign press_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/hex.sv
// BCD to active-low 7-segment decoder, segment order {g,f,e,d,c,b,a}.
// Codes above 9 show a blank digit.
module hex (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/countdown_timer.sv
// Four-digit BCD countdown timer (00.00-99.99 s) with set/change entry and alarm.
// Define COUNTDOWN_BLINK_EN to blink the digit being set and all digits in ALARM.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_CYCLES  = 1000000,
  parameter int unsigned BLINK_CYCLES = 25000000
) (
  input  logic       clk100_i,
  input  logic       rstn_i,
  input  logic       start_stop_i,
  input  logic       set_i,
  input  logic       change_i,
  output logic [6:0] hex0_o,
  output logic [6:0] hex1_o,
  output logic [6:0] hex2_o,
  output logic [6:0] hex3_o,
  output logic       alarm_o,
  output logic       running_o
);

  localparam int unsigned   PW        = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

  logic          ss_p, set_p, change_p;
  state_t        state_q, state_d;
  digits_t       dig_q, dig_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    set_idx;
  logic [3:0]    blank;
  logic [6:0]    seg [4];

  btn_edge u_btn_ss     (.clk100_i(clk100_i), .rstn_i(rstn_i), .btn_i(start_stop_i), .press_o(ss_p));
  btn_edge u_btn_set    (.clk100_i(clk100_i), .rstn_i(rstn_i), .btn_i(set_i),        .press_o(set_p));
  btn_edge u_btn_change (.clk100_i(clk100_i), .rstn_i(rstn_i), .btn_i(change_i),     .press_o(change_p));

  assign set_idx = 2'(state_q - SET0);

  // The prescaler only advances in RUN; a tick's decrement is applied even when paused in the same cycle.
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    presc_d = '0;
    case (state_q)
      IDLE: begin
        if (set_p) begin
          state_d = SET0;
        end else if (ss_p && (dig_q != '0)) begin
          state_d = RUN;
        end
      end
      SET0, SET1, SET2, SET3: begin
        if (set_p) begin
          state_d = (state_q == SET3) ? IDLE : state_t'(state_q + 3'd1);
        end else if (change_p) begin
          dig_d[set_idx] = (dig_q[set_idx] == BCD_MAX) ? 4'd0 : dig_q[set_idx] + 4'd1;
        end
      end
      RUN: begin
        if (presc_q == TICK_LAST) begin
          dig_d = bcd_dec(dig_q);
          if (dig_d == '0) begin
            state_d = ALARM;
          end else if (ss_p) begin
            state_d = IDLE;
          end
        end else begin
          presc_d = presc_q + 1'b1;
          if (ss_p) begin
            state_d = IDLE;
          end
        end
      end
      ALARM: begin
        if (ss_p || set_p || change_p) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      dig_q   <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      presc_q <= presc_d;
    end
  end

  assign alarm_o   = (state_q == ALARM);
  assign running_o = (state_q == RUN);

`ifdef COUNTDOWN_BLINK_EN
  localparam int unsigned   BW         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;

  // Restarting on every state change makes each new SET state begin with its digit visible.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_off_d = blink_off_q;
    if (state_d != state_q) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_off_d = ~blink_off_q;
    end
  end

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  always_comb begin
    blank = '0;
    if (blink_off_q) begin
      case (state_q)
        SET0, SET1, SET2, SET3: blank[set_idx] = 1'b1;
        ALARM:                  blank = 4'hF;
        default:                blank = '0;
      endcase
    end
  end
`else
  assign blank = '0;

  if (BLINK_CYCLES == 0) begin : g_blink_unused
  end
`endif

  for (genvar i = 0; i < 4; i++) begin : g_hex
    hex u_hex (.bcd_i(dig_q[i]), .seg_o(seg[i]));
  end

  assign hex0_o = blank[0] ? SEG_BLANK : seg[0];
  assign hex1_o = blank[1] ? SEG_BLANK : seg[1];
  assign hex2_o = blank[2] ? SEG_BLANK : seg[2];
  assign hex3_o = blank[3] ? SEG_BLANK : seg[3];

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer with TICK_CYCLES=4, BLINK_CYCLES=8.
// The reference value is kept as an integer number of hundredths.
module tb_countdown_timer;

  localparam int TICK  = 4;
  localparam int BLINK = 8;
  localparam int BTN_SS  = 0;
  localparam int BTN_SET = 1;
  localparam int BTN_CHG = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ss_n = 1'b1;
  logic set_n = 1'b1;
  logic chg_n = 1'b1;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic alarm, running;
  logic [29:0] obs;

  int checks = 0;
  int failures = 0;
  int model_val = 0;

  always #5 clk = ~clk;

  countdown_timer #(.TICK_CYCLES(TICK), .BLINK_CYCLES(BLINK)) dut (
    .clk100_i(clk), .rstn_i(rstn), .start_stop_i(ss_n), .set_i(set_n), .change_i(chg_n),
    .hex0_o(hex0), .hex1_o(hex1), .hex2_o(hex2), .hex3_o(hex3),
    .alarm_o(alarm), .running_o(running)
  );

  assign obs = {hex3, hex2, hex1, hex0, alarm, running};

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic int digit(input int v, input int n);
    return (v / pow10(n)) % 10;
  endfunction

  function automatic int bump_digit(input int v, input int n, input int count);
    return v + (((digit(v, n) + count) % 10) - digit(v, n)) * pow10(n);
  endfunction

  function automatic logic [29:0] exp_obs(input int v, input logic a, input logic r);
    return {seg7(digit(v, 3)), seg7(digit(v, 2)), seg7(digit(v, 1)), seg7(digit(v, 0)), a, r};
  endfunction

  task automatic drive_btn(input int which, input logic level);
    case (which)
      BTN_SS:  ss_n = level;
      BTN_SET: set_n = level;
      default: chg_n = level;
    endcase
  endtask

  // Raw low for one sampled edge; returns #1 after the edge where the effect is visible.
  task automatic press(input int which);
    @(negedge clk);
    drive_btn(which, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive_btn(which, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic enter_value(input int v);
    press(BTN_SET);
    for (int n = 0; n < 4; n++) begin
      repeat ((digit(v, n) - digit(model_val, n) + 10) % 10) press(BTN_CHG);
      press(BTN_SET);
    end
    model_val = v;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    edges(3);
    checks++;
    if (obs !== exp_obs(0, 1'b0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL reset_held: got %h expected %h", obs, exp_obs(0, 1'b0, 1'b0));
    end
    @(negedge clk);
    rstn = 1'b1;
    edges(3);
    checks++;
    if (obs !== exp_obs(0, 1'b0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL reset_released: got %h expected %h", obs, exp_obs(0, 1'b0, 1'b0));
    end
    model_val = 0;
  endtask

  task automatic test_entry;
    int v;
    press(BTN_SET);
    repeat (3) press(BTN_CHG);
    model_val = bump_digit(model_val, 0, 3);
    press(BTN_SET);
    checks++;
    if (obs !== exp_obs(model_val, 1'b0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL entry_in_set1: got %h expected %h", obs, exp_obs(model_val, 1'b0, 1'b0));
    end
    repeat (12) press(BTN_CHG);
    model_val = bump_digit(model_val, 1, 12);
    press(BTN_SET);
    press(BTN_SS);
    press(BTN_SET);
    press(BTN_CHG);
    model_val = bump_digit(model_val, 3, 1);
    press(BTN_SET);
    checks++;
    if (obs !== exp_obs(1023, 1'b0, 1'b0) || model_val != 1023) begin
      failures++;
      $display("[TB] FAIL entry_fixed: got %h expected %h", obs, exp_obs(1023, 1'b0, 1'b0));
    end
    repeat (3) begin
      v = $urandom_range(0, 9999);
      enter_value(v);
      checks++;
      if (obs !== exp_obs(v, 1'b0, 1'b0)) begin
        failures++;
        $display("[TB] FAIL entry_random %0d: got %h expected %h", v, obs, exp_obs(v, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_zero_start;
    enter_value(0);
    press(BTN_SS);
    checks++;
    if (obs !== exp_obs(0, 1'b0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL zero_start: got %h expected %h", obs, exp_obs(0, 1'b0, 1'b0));
    end
    edges(6);
    checks++;
    if (obs !== exp_obs(0, 1'b0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL zero_start_later: got %h expected %h", obs, exp_obs(0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_borrow_chain;
    enter_value(1000);
    press(BTN_SS);
    checks++;
    if (obs !== exp_obs(1000, 1'b0, 1'b1)) begin
      failures++;
      $display("[TB] FAIL borrow_start: got %h expected %h", obs, exp_obs(1000, 1'b0, 1'b1));
    end
    edges(TICK - 1);
    checks++;
    if (obs !== exp_obs(1000, 1'b0, 1'b1)) begin
      failures++;
      $display("[TB] FAIL borrow_pre_tick: got %h expected %h", obs, exp_obs(1000, 1'b0, 1'b1));
    end
    edges(1);
    checks++;
    if (obs !== exp_obs(999, 1'b0, 1'b1)) begin
      failures++;
      $display("[TB] FAIL borrow_first_tick: got %h expected %h", obs, exp_obs(999, 1'b0, 1'b1));
    end
    edges(999 * TICK - 1);
    checks++;
    if (obs !== exp_obs(1, 1'b0, 1'b1)) begin
      failures++;
      $display("[TB] FAIL borrow_last_run: got %h expected %h", obs, exp_obs(1, 1'b0, 1'b1));
    end
    edges(1);
    checks++;
    if (obs !== exp_obs(0, 1'b1, 1'b0)) begin
      failures++;
      $display("[TB] FAIL borrow_alarm: got %h expected %h", obs, exp_obs(0, 1'b1, 1'b0));
    end
    model_val = 0;
  endtask

  task automatic test_alarm_clear;
    edges(5);
    checks++;
    if (obs !== exp_obs(0, 1'b1, 1'b0)) begin
      failures++;
      $display("[TB] FAIL alarm_hold: got %h expected %h", obs, exp_obs(0, 1'b1, 1'b0));
    end
    press(BTN_CHG);
    checks++;
    if (obs !== exp_obs(0, 1'b0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL alarm_clear: got %h expected %h", obs, exp_obs(0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_pause_resume;
    int m;
    int expv;
    enter_value($urandom_range(200, 9999));
    press(BTN_SS);
    press(BTN_SS);
    checks++;
    if (obs !== exp_obs(model_val, 1'b0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL pause_p2: got %h expected %h", obs, exp_obs(model_val, 1'b0, 1'b0));
    end
    press(BTN_SS);
    edges(TICK - 1);
    checks++;
    if (obs !== exp_obs(model_val, 1'b0, 1'b1)) begin
      failures++;
      $display("[TB] FAIL resume_pre_tick: got %h expected %h", obs, exp_obs(model_val, 1'b0, 1'b1));
    end
    edges(1);
    model_val = model_val - 1;
    checks++;
    if (obs !== exp_obs(model_val, 1'b0, 1'b1)) begin
      failures++;
      $display("[TB] FAIL resume_tick: got %h expected %h", obs, exp_obs(model_val, 1'b0, 1'b1));
    end
    press(BTN_SS);
    repeat (4) begin
      m = $urandom_range(0, 9);
      press(BTN_SS);
      edges(m);
      press(BTN_SS);
      expv = model_val - (m + 3) / TICK;
      checks++;
      if (obs !== exp_obs(expv, 1'b0, 1'b0)) begin
        failures++;
        $display("[TB] FAIL pause_random m=%0d: got %h expected %h", m, obs, exp_obs(expv, 1'b0, 1'b0));
      end
      model_val = expv;
    end
    enter_value(1);
    press(BTN_SS);
    edges(1);
    press(BTN_SS);
    checks++;
    if (obs !== exp_obs(0, 1'b1, 1'b0)) begin
      failures++;
      $display("[TB] FAIL pause_on_last_tick: got %h expected %h", obs, exp_obs(0, 1'b1, 1'b0));
    end
    model_val = 0;
    press(BTN_SET);
    checks++;
    if (obs !== exp_obs(0, 1'b0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL alarm_clear_set: got %h expected %h", obs, exp_obs(0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_random_run;
    int v;
    int expv;
    logic a;
    repeat (2) begin
      v = $urandom_range(1, 40);
      enter_value(v);
      press(BTN_SS);
      for (int i = 0; i <= v * TICK; i++) begin
        expv = v - i / TICK;
        a = (i == v * TICK);
        checks++;
        if (obs !== exp_obs(expv, a, ~a)) begin
          failures++;
          $display("[TB] FAIL run_cycle v=%0d i=%0d: got %h expected %h", v, i, obs, exp_obs(expv, a, ~a));
        end
        edges(1);
      end
      model_val = 0;
      press(BTN_CHG);
    end
  endtask

  task automatic test_reset_mid_run;
    enter_value(537);
    press(BTN_SS);
    edges($urandom_range(2, 12));
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (obs !== exp_obs(0, 1'b0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL reset_mid_run: got %h expected %h", obs, exp_obs(0, 1'b0, 1'b0));
    end
    model_val = 0;
    @(negedge clk);
    rstn = 1'b1;
    edges(2);
    press(BTN_SS);
    checks++;
    if (obs !== exp_obs(0, 1'b0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL reset_then_start: got %h expected %h", obs, exp_obs(0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_blink;
    logic [13:0] exp_lo;
    logic blank_on;
    enter_value($urandom_range(0, 9999));
    press(BTN_SET);
    press(BTN_SET);
    for (int t = 0; t < 3 * BLINK; t++) begin
`ifdef COUNTDOWN_BLINK_EN
      blank_on = ((t / BLINK) % 2) == 1;
`else
      blank_on = 1'b0;
`endif
      exp_lo = {blank_on ? 7'b1111111 : seg7(digit(model_val, 1)), seg7(digit(model_val, 0))};
      checks++;
      if ({hex1, hex0} !== exp_lo) begin
        failures++;
        $display("[TB] FAIL set1_display t=%0d: got %h expected %h", t, {hex1, hex0}, exp_lo);
      end
      edges(1);
    end
    repeat (3) press(BTN_SET);
    checks++;
    if (obs !== exp_obs(model_val, 1'b0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL blink_exit_idle: got %h expected %h", obs, exp_obs(model_val, 1'b0, 1'b0));
    end
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_entry();
    test_zero_start();
    test_borrow_chain();
    test_alarm_clear();
    test_pause_resume();
    test_random_run();
    test_reset_mid_run();
    test_blink();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Four-digit BCD countdown timer (00.00–99.99 s) for the FPGA practicum board, the counting-down counterpart of the stopwatch. The user enters the start value digit by digit with the set/change buttons, then starts the timer with start/stop. It decrements every hundredth of a second and raises an alarm at 00.00. It drives the same four 7-segment outputs and uses the same three push-buttons.

## Interface
- `TICK_CYCLES`, default 1000000: clk100_i cycles per hundredth of a second. Must be ≥2.
- `BLINK_CYCLES`, default 25000000: half-period of the set-mode blink, used only with the blink macro.
- Reset `rstn_i` is asynchronous and active-low. Clock is `clk100_i`.
- `clk100_i` in 1: 100 MHz system clock.
- `rstn_i` in 1: asynchronous active-low reset.
- `start_stop_i` in 1: raw button, low = pressed.
- `set_i` in 1: raw button, low = pressed.
- `change_i` in 1: raw button, low = pressed.
- `hex0_o`..`hex3_o` out 7 each: active-low segments for hundredths, tenths, seconds and tens of seconds.
- `alarm_o` out 1: high while in ALARM.
- `running_o` out 1: high while in RUN.

## Operation
- **Button inputs**
  - Each button is inverted and passed through a 3-flop chain.
  - A press pulse is `s[1] & ~s[2]`: exactly one cycle per falling edge of the raw input.
  - There is no debounce.
- **Digits:** d0..d3 are 4-bit BCD, each held in 0..9.
- **FSM states:** IDLE, SET0, SET1, SET2, SET3, RUN, ALARM.
- **IDLE**
  - set → SET0.
  - start_stop with value ≠ 00.00 → RUN.
  - start_stop with value = 00.00 is ignored.
  - change is ignored.
- **SETn**
  - change increments dn, wrapping 9→0.
  - set → SET(n+1). From SET3, set → IDLE.
  - start_stop is ignored.
- **RUN**
  - The prescaler counts 0..TICK_CYCLES-1. The tick is asserted in the cycle where it equals TICK_CYCLES-1, and the prescaler then wraps to 0.
  - On each tick the 4-digit value is BCD-decremented with borrow. Example: 10.00 → 09.99.
  - If the decremented value is 00.00 → ALARM.
  - start_stop → IDLE (pause).
  - set and change are ignored.
- **ALARM**
  - Digits hold 00.00 and `alarm_o` = 1.
  - Any button press → IDLE, which clears `alarm_o`.
- **Prescaler clearing:** the prescaler is cleared to 0 in every state other than RUN. Pausing therefore discards the partial hundredth.
- **Simultaneous start_stop and tick in RUN:** the decrement is applied. The next state is IDLE, unless the result is 00.00, in which case ALARM wins.
- **Simultaneous set and change in SETn:** set wins and the digit is not incremented.

## Timing
- **Reset values:** state IDLE, d0..d3 = 0, prescaler 0, `alarm_o` = 0, `running_o` = 0. Every `hex*_o` shows the decoded "0".
- **Press latency:** a raw falling edge sampled at edge k gives a press pulse in the cycle after edge k+1. The state, digit or output change is visible after edge k+2.
- **Outputs:** `alarm_o` and `running_o` are decoded from the registered state, so they change in the same cycle as the state.
- **Tick cadence:** the first tick comes TICK_CYCLES cycles after entering RUN, then one every TICK_CYCLES cycles.
- **Digit path:** each digit update is registered, and the `hex` decode is combinational after it.
- **Reset mid-count:** everything returns immediately to the reset values, and the entered value is lost.

## Configuration
- **`COUNTDOWN_BLINK_EN` defined**
  - In SETn, the output for digit n is forced to 7'b1111111 (blank) during alternate BLINK_CYCLES periods.
  - The blink counter is cleared on every state change, so each SET state starts with the digit visible.
  - In ALARM, all four digits blink the same way.
- **`COUNTDOWN_BLINK_EN` not defined**
  - Digits are always displayed.
  - No blink counter exists and `BLINK_CYCLES` is unused.

## Structure
- **Shared package `countdown_pkg`:**
  - state encoding localparams: IDLE=0, SET0..SET3=1..4, RUN=5, ALARM=6, 3 bits;
  - `BCD_MAX` = 4'd9;
  - the blank pattern 7'b1111111.
- **Sub-module `btn_edge`:** one instance per button. It contains the synchronizer and edge detector, with ports clk100_i, rstn_i, btn_i and press_o.
- **Decoding:** the four digits are decoded with the existing `hex` decoder.

## Test plan
All scenarios use TICK_CYCLES=4 and BLINK_CYCLES=8.
- **Reset:** assert rstn_i mid-RUN at value 05.37 → all digits 0, IDLE, `alarm_o` = 0, `running_o` = 0 in the same cycle.
- **Entry**
  - Stimulus: set; change ×3; set; change ×12; set; set; change ×1; set.
  - Required response: value 10.23 (the d1 wrap is exercised), IDLE.
- **Borrow chain:** load 10.00, start → the first tick gives 09.99 on the 4th clock after the press-visible cycle. After 1000 ticks → ALARM with `alarm_o` = 1.
- **Zero start:** start_stop at 00.00 → stays IDLE, `running_o` = 0.
- **Pause/resume**
  - Pause at prescaler=2 → the prescaler clears.
  - Resume → the next tick comes a full 4 cycles later.
  - Stimulus: start_stop pressed in a tick cycle at 00.01 → ALARM, not IDLE.
- **Alarm clear and blink:** change press in ALARM → IDLE, `alarm_o` = 0. With `COUNTDOWN_BLINK_EN`, hex1_o in SET1 alternates every 8 cycles between the decode of d1 and 7'b1111111.
